// File: rtl/counter_123_arb.sv
// counter_123_arb
//   Shares one registered (1,2,3) generalized parallel counter between NREQ
//   requesters. One requester is granted per cycle. Its operands and index
//   pass through the S1 operand/tag register. The counter result is written
//   into a show-ahead response FIFO that uses credit-based flow control.
//
//   Arbitration: with COUNTER_123_ARB_RR_EN defined, the grant is round-robin
//   from a priority pointer. Without it, the grant is fixed priority and the
//   lowest index wins.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept (at most one bit high)
//   req_c0     weight-1 bits, requester i at [3i+2:3i]
//   req_c1     weight-2 bits, requester i at [2i+1:2i]
//   req_c2     weight-4 bit, requester i at [i]
//   rsp_valid  response FIFO head valid
//   rsp_ready  response consumer accept
//   rsp_o      counter result of the head entry (0..11)
//   rsp_id     requester index of the head entry
//   busy       registered; high while S1 or the FIFO holds an operation
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Valid never waits for ready. Ready may depend on
// valid. req_ready is derived only from req_valid and registered state, so
// rsp_ready has no combinational path to req_ready.

module counter_123_arb #(
   parameter int NREQ       = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int ID_W       = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [3*NREQ-1:0] req_c0,
   input  logic [2*NREQ-1:0] req_c1,
   input  logic [NREQ-1:0]   req_c2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [3:0]        rsp_o,
   output logic [ID_W-1:0]   rsp_id,
   output logic              busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   // ---------------------------------------------------------------- arbiter
   logic            win_valid;
   logic [ID_W-1:0] win_id;

`ifdef COUNTER_123_ARB_RR_EN
   logic [ID_W-1:0] ptr;

   // Rotate the requests so that bit 0 is the pointer position. The first
   // set bit gives the offset from ptr. Adding the offset back and wrapping
   // at NREQ gives the winner.
   logic [2*NREQ-1:0] rr_dbl;
   logic [NREQ-1:0]   rr_rot;
   logic [ID_W-1:0]   rr_off;
   logic [ID_W:0]     rr_sum;

   always_comb begin
      rr_dbl    = {req_valid, req_valid} >> ptr;
      rr_rot    = rr_dbl[NREQ-1:0];
      rr_off    = '0;
      win_valid = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rr_rot[k]) begin
            win_valid = 1'b1;
            rr_off    = ID_W'(k);
         end
      end
      rr_sum = {1'b0, ptr} + {1'b0, rr_off};
      if (rr_sum >= (ID_W + 1)'(NREQ)) begin
         rr_sum = rr_sum - (ID_W + 1)'(NREQ);
      end
      win_id = rr_sum[ID_W-1:0];
   end
`else
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            win_valid = 1'b1;
            win_id    = ID_W'(k);
         end
      end
   end
`endif

   // ------------------------------------------------------- credit / accept
   logic             s1_valid;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   occupancy;
   logic             can_issue;
   logic             hs;

   // credit > 0 is the same as occupancy < FIFO_DEPTH. S1 is counted because
   // S1 is committed to a FIFO slot on the next edge.
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
   assign can_issue = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
   assign hs        = rst_n & can_issue & win_valid;

   always_comb begin
      req_ready = '0;
      if (hs) req_ready[win_id] = 1'b1;
   end

   // Select the operands of the winning requester.
   logic [2:0] sel_c0;
   logic [1:0] sel_c1;
   logic       sel_c2;

   always_comb begin
      sel_c0 = '0;
      sel_c1 = '0;
      sel_c2 = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (win_id == ID_W'(k)) begin
            sel_c0 = req_c0[3*k +: 3];
            sel_c1 = req_c1[2*k +: 2];
            sel_c2 = req_c2[k];
         end
      end
   end

   // ------------------------------------------------------- S1 and counter
   logic [2:0]      s1_c0;
   logic [1:0]      s1_c1;
   logic            s1_c2;
   logic [ID_W-1:0] s1_id;
   logic [3:0]      cnt_res;

   assign cnt_res = 4'(s1_c0[0]) + 4'(s1_c0[1]) + 4'(s1_c0[2])
                  + (4'(s1_c1[0]) << 1) + (4'(s1_c1[1]) << 1)
                  + (4'(s1_c2) << 2);

   // -------------------------------------------------------------- FIFO
   // The FIFO slot written from S1 acts as the S2 result/tag register. This
   // keeps handshake-to-rsp_valid latency at two cycles.
   logic [3:0]       mem_res [FIFO_DEPTH];
   logic [ID_W-1:0]  mem_id  [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count_next;

   assign rsp_valid = (fifo_count != '0);
   assign push      = s1_valid;
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_o     = rsp_valid ? mem_res[rd_ptr] : 4'd0;
   assign rsp_id    = rsp_valid ? mem_id[rd_ptr] : '0;

   always_comb begin
      count_next = fifo_count;
      if (push && !pop) count_next = fifo_count + CNT_W'(1);
      if (!push && pop) count_next = fifo_count - CNT_W'(1);
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage is data only. The valid state lives in fifo_count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_res[wr_ptr] <= cnt_res;
         mem_id[wr_ptr]  <= s1_id;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_c0      <= '0;
         s1_c1      <= '0;
         s1_c2      <= 1'b0;
         s1_id      <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         busy       <= 1'b0;
      end else begin
         s1_valid <= hs;
         if (hs) begin
            s1_c0 <= sel_c0;
            s1_c1 <= sel_c1;
            s1_c2 <= sel_c2;
            s1_id <= win_id;
         end
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_count <= count_next;
         // Next-cycle occupancy: S1 holds an op after hs, or the FIFO is non-empty.
         busy <= hs | (count_next != '0);
      end
   end

`ifdef COUNTER_123_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (hs) begin
         ptr <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_counter_123_arb.sv
// tb_counter_123_arb
//   Directed and random stimulus for counter_123_arb. A transaction-level
//   model predicts the outputs every cycle. The model holds the issued
//   operations that are not yet consumed. Its results are popcount arithmetic
//   on the operands. An operation becomes visible two cycles after issue, and
//   credit is FIFO_DEPTH minus the outstanding operations.

module tb_counter_123_arb;

   localparam int NREQ       = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int ID_W       = 2;

   // ------------------------------------------------------ clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [3*NREQ-1:0] req_c0;
   logic [2*NREQ-1:0] req_c1;
   logic [NREQ-1:0]   req_c2;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [3:0]        rsp_o;
   logic [ID_W-1:0]   rsp_id;
   logic              busy;

   counter_123_arb #(
      .NREQ       (NREQ),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_c0    (req_c0),
      .req_c1    (req_c1),
      .req_c2    (req_c2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_o     (rsp_o),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   // ------------------------------------------------------ scoreboard
   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int m_ptr  = 0;
   logic m_last_hs;
   logic [ID_W+3:0] exp_q[$];   // {id, result}, oldest first
   int t_q[$];                  // issue cycle of each exp_q entry
   int hs_by[NREQ];
   int hs_total;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_winner(input logic [NREQ-1:0] v, input int base);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (base + k) % NREQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic clear_tally();
      hs_total = 0;
      for (int k = 0; k < NREQ; k++) hs_by[k] = 0;
   endtask

   // Call at a negedge with the inputs already driven. Checks the outputs,
   // advances one clock and updates the model. Returns at the next negedge.
   task automatic step();
      int w;
      int base;
      logic [NREQ-1:0] e_ready;
      logic e_rv;
      logic m_pop;
      logic [2:0] c0;
      logic [1:0] c1;
      logic c2;
      logic [3:0] e_res;
      #1;
`ifdef COUNTER_123_ARB_RR_EN
      base = m_ptr;
`else
      base = 0;
`endif
      w = model_winner(req_valid, base);
      e_ready = '0;
      if (rst_n && w >= 0 && exp_q.size() < FIFO_DEPTH) e_ready[w] = 1'b1;
      e_rv = (exp_q.size() > 0) && (t_q[0] <= cycle - 2);
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
      if (e_rv) begin
         check("rsp_o", 32'(rsp_o), 32'(exp_q[0][3:0]));
         check("rsp_id", 32'(rsp_id), 32'(exp_q[0][ID_W+3:4]));
      end
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[k] && req_ready[k]) begin
            hs_by[k]++;
            hs_total++;
         end
      end
      m_last_hs = (e_ready != '0);
      m_pop = e_rv && rsp_ready;
      e_res = '0;
      if (w >= 0) begin
         c0 = req_c0[3*w +: 3];
         c1 = req_c1[2*w +: 2];
         c2 = req_c2[w];
         e_res = 4'($countones(c0) + 2 * $countones(c1) + 4 * int'(c2));
      end
      @(posedge clk);
      if (!rst_n) begin
         exp_q.delete();
         t_q.delete();
         m_ptr = 0;
         m_last_hs = 1'b0;
      end else begin
         if (m_pop) begin
            void'(exp_q.pop_front());
            void'(t_q.pop_front());
         end
         if (m_last_hs) begin
            exp_q.push_back({ID_W'(w), e_res});
            t_q.push_back(cycle);
            m_ptr = (w + 1) % NREQ;
         end
      end
      cycle++;
      @(negedge clk);
   endtask

   // ------------------------------------------------------ driver tasks
   task automatic rand_ops();
      req_c0 = (3*NREQ)'($urandom);
      req_c1 = (2*NREQ)'($urandom);
      req_c2 = NREQ'($urandom);
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (FIFO_DEPTH + 4) step();
   endtask

   // ------------------------------------------------------ stimulus
   initial begin
      int combo;
      int guard;
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_c0    = '0;
      req_c1    = '0;
      req_c2    = '0;
      m_last_hs = 1'b0;
      clear_tally();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_o", 32'(rsp_o), 32'd0);
      check("reset_rsp_id", 32'(rsp_id), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd0);

      // Single issue from requester 2: 3 + 2*2 + 4 = 11.
      req_valid = 4'b0100;
      req_c0    = 12'b000_111_000_000;
      req_c1    = 8'b00_11_00_00;
      req_c2    = 4'b0100;
      rsp_ready = 1'b1;
      step();
      req_valid = '0;
      step();
      #1;
      check("single_rsp_valid", 32'(rsp_valid), 32'd1);
      check("single_rsp_o", 32'(rsp_o), 32'd11);
      check("single_rsp_id", 32'(rsp_id), 32'd2);
      step();
      step();
      check("single_busy_drop", 32'(busy), 32'd0);

      // All requesters held valid.
      clear_tally();
      req_valid = '1;
      for (int i = 0; i < 12; i++) begin
         rand_ops();
         step();
      end
`ifdef COUNTER_123_ARB_RR_EN
      for (int k = 0; k < NREQ; k++) check("rr_share", 32'(hs_by[k]), 32'd3);
`else
      check("fixed_share0", 32'(hs_by[0]), 32'd12);
`endif
      drain();

      // Back-pressure from requester 1 with the consumer stalled.
      clear_tally();
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rand_ops();
         step();
      end
      check("bp_handshakes", 32'(hs_total), 32'(FIFO_DEPTH));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_ops();
         step();
      end
      check("bp_one_more", 32'(hs_total), 32'(FIFO_DEPTH + 1));
      drain();

      // Reset while two operations are in flight.
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_ops();
         step();
      end
      req_valid = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      repeat (4) step();

      // Requesters 0 and 3 contend.
      clear_tally();
      req_valid = 4'b1001;
      for (int i = 0; i < 10; i++) begin
         rand_ops();
         step();
      end
`ifdef COUNTER_123_ARB_RR_EN
      check("pair_req3", 32'(hs_by[3]), 32'd5);
`else
      check("fixed_req0", 32'(hs_by[0]), 32'd10);
      check("fixed_req3", 32'(hs_by[3]), 32'd0);
`endif
      req_valid = 4'b1000;
      step();
      step();
      check("req3_after_drop", 32'(hs_by[3] > 0), 32'd1);
      drain();

      // All 64 operand combinations from requester 0.
      combo = 0;
      guard = 0;
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      while (combo < 64 && guard < 300) begin
         req_c0 = {9'd0, 3'(combo)};
         req_c1 = {6'd0, 2'(combo >> 3)};
         req_c2 = {3'd0, 1'(combo >> 5)};
         step();
         if (m_last_hs) combo++;
         guard++;
      end
      check("sweep_done", 32'(combo), 32'd64);
      drain();

      // Random traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         req_valid = NREQ'($urandom);
         rand_ops();
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/counter_123_arb.md
# counter_123_arb

Round-robin arbiter and scheduler that shares one registered (1,2,3) generalized parallel counter between `NREQ` requesters. Each requester presents one operand set: three weight-1 bits, two weight-2 bits and one weight-4 bit. The block grants one requester per cycle, tags the issued operation with the requester index, and runs it through the counter pipeline. Results land in a credit-protected response FIFO with valid/ready back-pressure. It sits between compressor-tree control logic and the single shared counter datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `FIFO_DEPTH`, 4: response FIFO entries, ≥2.
- `ID_W`, `$clog2(NREQ)`: requester tag width (derived).

- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NREQ: per-requester operand valid.
- `req_ready` out NREQ: per-requester grant/accept; at most one bit high.
- `req_c0` in 3*NREQ: weight-1 bits, requester i at [3i+2:3i].
- `req_c1` in 2*NREQ: weight-2 bits, requester i at [2i+1:2i].
- `req_c2` in NREQ: weight-4 bit, requester i at [i].
- `rsp_valid` out 1: response FIFO head valid.
- `rsp_ready` in 1: response consumer accept.
- `rsp_o` out 4: counter result.
- `rsp_id` out ID_W: index of the requester that produced `rsp_o`.
- `busy` out 1: high while any operation is in the pipeline or the FIFO.

## Operation
- **Result:** `rsp_o = popcount(c0) + 2*popcount(c1) + 4*c2`.
  - Range is 0..11, zero-extended to 4 bits, with no overflow.
- **Accept:** a handshake is `req_valid[i] & req_ready[i]` in one cycle.
  - `req_ready[i]` is high only if `req_valid[i]` is high, i is the arbitration winner, and `credit > 0`.
  - `req_valid` must not depend on `req_ready`.
- **Credit:** `credit = FIFO_DEPTH - fifo_count - inflight`.
  - `inflight` counts valid entries in pipeline stage S1 (0 or 1).
  - `credit` is computed from registered state only. A pop in cycle T raises `credit` in T+1; there is no combinational path from `rsp_ready` to `req_ready`.
- **Pipeline stages:**
  - S1 is the operand/tag register, captured at the handshake.
  - S2 is the counter output register plus tag, which writes the FIFO.
- **FIFO:** show-ahead. `rsp_valid`, `rsp_o` and `rsp_id` are driven from the head entry. Pop on `rsp_valid & rsp_ready`.
  - A push and a pop in the same cycle with a non-empty FIFO leaves the count unchanged.
  - A push into an empty FIFO is not bypassed; the head appears next cycle.
- **Arbitration:** the priority pointer `ptr` is in 0..NREQ-1. The winner is the first `req_valid` bit scanning `ptr, ptr+1, …` mod NREQ.
  - After a handshake by i: `ptr <= (i+1) mod NREQ`, wrapping NREQ-1 → 0.
  - With no handshake, `ptr` holds, including while stalled on credit.
- **Reset (`rst_n` low at an edge):**
  - `ptr` = 0.
  - S1/S2 valid cleared, in-flight operations discarded.
  - FIFO emptied.
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_o` = 0, `rsp_id` = 0, `busy` = 0.
  - This applies mid-operation, and the next cycle behaves as after power-up.
- **Simultaneous requests:** exactly one is granted; the others stay pending with `req_ready` low.
- **FIFO full or credit 0:** every `req_ready` is low. Pipeline contents are never dropped.

## Timing
- A handshake in cycle T captures S1 at the end of T and S2 at the end of T+1.
  - The FIFO is written at the end of T+1.
  - If the FIFO was empty, `rsp_valid` is high in T+2. End-to-end latency is 2 cycles.
- Throughput is one issue per cycle when `rsp_ready` is held high and `FIFO_DEPTH` ≥ 3.
- `busy` is registered and is high in the cycle after any handshake, until S1 and S2 are empty and the FIFO is empty.
- Responses leave in issue order.

## Configuration
- `COUNTER_123_ARB_RR_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority.
  - The lowest-index valid requester always wins.
  - `ptr` logic is removed.
  - All other behaviour, including credit, latency and reset, is identical.

## Test plan
- **Single issue:** after reset, requester 2 presents c0=3'b111, c1=2'b11, c2=1, with `rsp_ready`=1. Expect the handshake in T, then `rsp_valid`=1, `rsp_o`=11 and `rsp_id`=2 in T+2. `busy` then drops.
- **Round-robin:** all four `req_valid` held high (RR_EN defined). Grants go 0,1,2,3,0,… one per cycle, and `rsp_id` follows the same order with no gaps.
- **Back-pressure:** `rsp_ready`=0, `FIFO_DEPTH`=4, requester 1 streaming.
  - Exactly 4 handshakes occur, then `req_ready` stays 0.
  - Raising `rsp_ready` for one cycle yields exactly one more handshake, one cycle later.
- **Reset mid-operation:** issue 3 operations, then assert `rst_n`=0 for 1 cycle while 2 are in flight. Afterwards `rsp_valid`=0, `busy`=0, and no stale response ever appears.
- **Fixed priority:** macro undefined, requesters 0 and 3 held valid. Requester 0 is granted every cycle and requester 3 never, until `req_valid[0]` drops.
- **Arithmetic sweep:** all 64 operand combinations issued from requester 0. Each `rsp_o` equals `popcount(c0) + 2*popcount(c1) + 4*c2`, for example c0=3'b010, c1=2'b01, c2=0 gives 3.
